miner_host_seq: RTL and testbench

//  Hardware initiator for the core's network-packet interface: replaces the bench-side mining sequencer.

---
 rtl/miner_host_seq_pkg.sv | 52 +++++
 rtl/miner_host_pkt_gen.sv | 71 +++++++
 rtl/miner_host_seq.sv | 178 +++++++++++++++++
 tb/tb_miner_host_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/miner_host_seq_pkg.sv
// Shared definitions for the mining host sequencer: network packet layout,
// miner command codes and sequencer states.
package miner_host_seq_pkg;

    typedef enum logic [2:0] {
        OP_NULL  = 3'd0,
        OP_INSTR = 3'd1,
        OP_REG   = 3'd2,
        OP_PC    = 3'd3,
        OP_BAR   = 3'd4
    } net_op_e;

    typedef struct packed {
        logic [9:0]  id;
        net_op_e     op;
        logic [9:0]  net_addr;
        logic [31:0] net_data;
    } net_packet_s;

    // CMD_NONE only exists as the post-reset value of the command register.
    typedef enum logic [1:0] {
        CMD_NONE    = 2'd0,
        CMD_LDWORK  = 2'd1,
        CMD_LDNONCE = 2'd2,
        CMD_DONE    = 2'd3
    } miner_cmd_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_BAR,
        ST_MID,
        ST_WORK,
        ST_CMD,
        ST_PC,
        ST_QUIET,
        ST_WAIT,
        ST_NONCE,
        ST_DONE
    } miner_host_state_e;

    localparam logic [31:0] NULL_DATA = 32'hFFFF_FFFE;

    function automatic net_packet_s null_pkt(input logic [9:0] id, input logic [9:0] addr);
        net_packet_s p;
        p.id       = id;
        p.op       = OP_NULL;
        p.net_addr = addr;
        p.net_data = NULL_DATA;
        return p;
    endfunction

endpackage

// File: rtl/miner_host_pkt_gen.sv
// Combinational packet builder: maps the sequencer state, word index, nonce
// and pending command onto the packet to be registered next cycle.
module miner_host_pkt_gen
    import miner_host_seq_pkg::*;
#(
    parameter logic [9:0]  CORE_ID_P    = 10'd1,
    parameter logic [31:0] BAR_MASK_P   = 32'd7,
    parameter logic [9:0]  BAR_ADDR_P   = 10'd24,
    parameter logic [31:0] START_PC_P   = 32'h2,
    parameter logic [9:0]  CMD_ADDR_P   = 10'd20,
    parameter logic [9:0]  NONCE_ADDR_P = 10'd1
) (
    input  miner_host_state_e state_i,
    input  logic [2:0]        idx_i,
    input  logic [255:0]      midstate_i,
    input  logic [95:0]       work_i,
    input  logic [31:0]       nonce_i,
    input  miner_cmd_e        cmd_i,
    output net_packet_s       pkt_o
);

    logic [7:0][31:0] mid_w;
    logic [31:0]      work_w;

    assign mid_w = midstate_i;

    always_comb begin
        unique case (idx_i[1:0])
            2'd0:    work_w = work_i[31:0];
            2'd1:    work_w = work_i[63:32];
            default: work_w = work_i[95:64];
        endcase
    end

    always_comb begin
        pkt_o = null_pkt(CORE_ID_P, BAR_ADDR_P);
        unique case (state_i)
            ST_BAR: begin
                pkt_o.op       = OP_BAR;
                pkt_o.net_data = BAR_MASK_P;
            end
            ST_MID: begin
                pkt_o.op       = OP_REG;
                pkt_o.net_addr = 10'd1 + {7'd0, idx_i};
                pkt_o.net_data = mid_w[idx_i];
            end
            ST_WORK: begin
                pkt_o.op       = OP_REG;
                pkt_o.net_addr = 10'd9 + {7'd0, idx_i};
                pkt_o.net_data = work_w;
            end
            ST_CMD: begin
                pkt_o.op       = OP_REG;
                pkt_o.net_addr = CMD_ADDR_P;
                pkt_o.net_data = {30'd0, cmd_i};
            end
            ST_PC: begin
                pkt_o.op       = OP_PC;
                pkt_o.net_addr = '0;
                pkt_o.net_data = START_PC_P;
            end
            ST_NONCE: begin
                pkt_o.op       = OP_REG;
                pkt_o.net_addr = NONCE_ADDR_P;
                pkt_o.net_data = nonce_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/miner_host_seq.sv
// Mining host sequencer: loads midstate/work into the core, steps the nonce
// through the core's command register and watches barrier_i for the verdict.
module miner_host_seq
    import miner_host_seq_pkg::*;
#(
    parameter logic [9:0]  CORE_ID_P    = 10'd1,
    parameter logic [31:0] BAR_MASK_P   = 32'd7,
    parameter logic [9:0]  BAR_ADDR_P   = 10'd24,
    parameter logic [31:0] START_PC_P   = 32'h2,
    parameter logic [9:0]  CMD_ADDR_P   = 10'd20,
    parameter logic [9:0]  NONCE_ADDR_P = 10'd1,
    parameter int unsigned SETTLE_P     = 2,
    parameter int unsigned TIMEOUT_P    = 2**20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_i,
    input  logic [255:0] midstate_i,
    input  logic [95:0]  work_i,
    input  logic [31:0]  nonce_start_i,
    input  logic [31:0]  nonce_last_i,
    input  logic [2:0]   barrier_i,
    output net_packet_s  net_packet_o,
    output logic         busy_o,
    output logic         found_o,
    output logic [31:0]  found_nonce_o,
    output logic         exhausted_o,
    output logic         error_o
);

    localparam int unsigned SW = $clog2(SETTLE_P + 2);
    localparam int unsigned TW = $clog2(TIMEOUT_P + 2);

    miner_host_state_e state_q;
    miner_cmd_e        cmd_q;
    logic [2:0]        idx_q;
    logic [SW-1:0]     settle_q;
    logic [TW-1:0]     tmo_q;
    logic [31:0]       nonce_q, last_q, found_nonce_q;
    logic [255:0]      mid_q;
    logic [95:0]       work_q;
    logic              busy_q, found_q, exhausted_q, error_q;
    net_packet_s       net_packet_q, pkt_d;

    miner_host_pkt_gen #(
        .CORE_ID_P   (CORE_ID_P),
        .BAR_MASK_P  (BAR_MASK_P),
        .BAR_ADDR_P  (BAR_ADDR_P),
        .START_PC_P  (START_PC_P),
        .CMD_ADDR_P  (CMD_ADDR_P),
        .NONCE_ADDR_P(NONCE_ADDR_P)
    ) u_pkt_gen (
        .state_i   (state_q),
        .idx_i     (idx_q),
        .midstate_i(mid_q),
        .work_i    (work_q),
        .nonce_i   (nonce_q),
        .cmd_i     (cmd_q),
        .pkt_o     (pkt_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cmd_q         <= CMD_NONE;
            idx_q         <= '0;
            settle_q      <= '0;
            tmo_q         <= '0;
            nonce_q       <= '0;
            last_q        <= '0;
            found_nonce_q <= '0;
            mid_q         <= '0;
            work_q        <= '0;
            busy_q        <= 1'b0;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
            error_q       <= 1'b0;
            net_packet_q  <= null_pkt(CORE_ID_P, BAR_ADDR_P);
        end else begin
            net_packet_q <= pkt_d;
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        mid_q         <= midstate_i;
                        work_q        <= work_i;
                        last_q        <= nonce_last_i;
                        nonce_q       <= nonce_start_i;
                        found_nonce_q <= '0;
                        found_q       <= 1'b0;
                        exhausted_q   <= 1'b0;
                        error_q       <= 1'b0;
                        busy_q        <= 1'b1;
                        state_q       <= ST_BAR;
                    end
                end
                ST_BAR: begin
                    idx_q   <= '0;
                    state_q <= ST_MID;
                end
                ST_MID: begin
                    idx_q <= idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        idx_q   <= '0;
                        state_q <= ST_WORK;
                    end
                end
                ST_WORK: begin
                    idx_q <= idx_q + 3'd1;
                    if (idx_q == 3'd2) begin
                        cmd_q   <= CMD_LDWORK;
                        state_q <= ST_CMD;
                    end
                end
                ST_CMD:   state_q <= ST_PC;
                ST_PC:    state_q <= ST_QUIET;
                ST_QUIET: begin
                    settle_q <= SW'(SETTLE_P);
                    tmo_q    <= '0;
                    state_q  <= ST_WAIT;
                end
                ST_WAIT: begin
                    tmo_q <= tmo_q + TW'(1);
                    // Timeout outranks everything; barrier is only trusted once settled.
                    if (tmo_q == TW'(TIMEOUT_P)) begin
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end else if (settle_q != '0) begin
                        settle_q <= settle_q - SW'(1);
                    end else if (barrier_i == 3'b000) begin
                        unique case (cmd_q)
                            CMD_LDNONCE: begin
                                if (nonce_q == last_q) begin
                                    exhausted_q <= 1'b1;
                                    cmd_q       <= CMD_DONE;
                                    state_q     <= ST_CMD;
                                end else begin
                                    nonce_q <= nonce_q + 32'd1;
                                    state_q <= ST_NONCE;
                                end
                            end
                            CMD_DONE: begin
                                busy_q  <= 1'b0;
                                state_q <= ST_DONE;
                            end
                            default: state_q <= ST_NONCE;
                        endcase
                    end else if (barrier_i == 3'b001) begin
                        // A lingering hit after CMD_DONE just keeps us waiting.
                        if (cmd_q != CMD_DONE) begin
                            found_q       <= 1'b1;
                            found_nonce_q <= nonce_q;
                            cmd_q         <= CMD_DONE;
                            state_q       <= ST_CMD;
                        end
                    end else begin
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end
                end
                ST_NONCE: begin
                    cmd_q   <= CMD_LDNONCE;
                    state_q <= ST_CMD;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign net_packet_o  = net_packet_q;
    assign busy_o        = busy_q;
    assign found_o       = found_q;
    assign found_nonce_o = found_nonce_q;
    assign exhausted_o   = exhausted_q;
    assign error_o       = error_q;

endmodule

// File: tb/tb_miner_host_seq.sv
// Randomized bench for miner_host_seq: a register-level core model answers on
// barrier_i, and a job-level reference predicts packet stream and flags.
module tb_miner_host_seq;
    import miner_host_seq_pkg::*;

    localparam int unsigned SETTLE = 2;
    localparam int unsigned TMO    = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start_i = 1'b0;
    logic [255:0] midstate_i = '0;
    logic [95:0]  work_i = '0;
    logic [31:0]  nonce_start_i = '0;
    logic [31:0]  nonce_last_i = '0;
    logic [2:0]   barrier_i = 3'b000;
    net_packet_s  net_packet_o;
    logic         busy_o, found_o, exhausted_o, error_o;
    logic [31:0]  found_nonce_o;

    always #5 clk = ~clk;

    miner_host_seq #(
        .CORE_ID_P   (10'd1),
        .BAR_MASK_P  (32'd7),
        .BAR_ADDR_P  (10'd24),
        .START_PC_P  (32'h2),
        .CMD_ADDR_P  (10'd20),
        .NONCE_ADDR_P(10'd1),
        .SETTLE_P    (SETTLE),
        .TIMEOUT_P   (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .midstate_i   (midstate_i),
        .work_i       (work_i),
        .nonce_start_i(nonce_start_i),
        .nonce_last_i (nonce_last_i),
        .barrier_i    (barrier_i),
        .net_packet_o (net_packet_o),
        .busy_o       (busy_o),
        .found_o      (found_o),
        .found_nonce_o(found_nonce_o),
        .exhausted_o  (exhausted_o),
        .error_o      (error_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic net_packet_s pk(input net_op_e op, input logic [9:0] a, input logic [31:0] d);
        net_packet_s p;
        p.id = 10'd1; p.op = op; p.net_addr = a; p.net_data = d;
        return p;
    endfunction

    net_packet_s NULLP;
    initial NULLP = pk(OP_NULL, 10'd24, 32'hFFFF_FFFE);

    // Core model knobs and register file
    logic [31:0] cregs [0:31];
    bit          pend = 0;
    int          settle_cnt = 0;
    logic [2:0]  stale_val = 3'b000;
    logic [2:0]  done_resp = 3'b000;
    bit          err_mode = 0;
    bit          hit_en = 0;
    logic [31:0] hit_n = '0;

    function automatic logic [2:0] core_response();
        case (cregs[20])
            32'd2: begin
                if (err_mode) return 3'b010;
                if (hit_en && cregs[1] == hit_n) return 3'b001;
                return 3'b000;
            end
            32'd3:   return done_resp;
            default: return 3'b000;
        endcase
    endfunction

    // Core runs after every PC packet; barrier carries junk until settled.
    always @(negedge clk) begin : core_model
        net_packet_s p;
        p = net_packet_o;
        if (reset) begin
            pend = 0;
            settle_cnt = 0;
        end else begin
            if (settle_cnt > 0) begin
                settle_cnt--;
                if (settle_cnt == 0) barrier_i = core_response();
            end
            case (p.op)
                OP_REG: cregs[p.net_addr[4:0]] = p.net_data;
                OP_PC:  pend = 1;
                OP_NULL: if (pend) begin
                    pend = 0;
                    barrier_i = stale_val;
                    settle_cnt = SETTLE;
                end
                default: ;
            endcase
        end
    end

    net_packet_s exp_q[$];
    net_packet_s got_q[$];
    bit          ef, ex, er;
    logic [31:0] efn;

    task automatic build_expect(input logic [255:0] mid, input logic [95:0] wk,
                                input logic [31:0] ns, input logic [31:0] nl);
        logic [31:0] n;
        exp_q.delete();
        ef = 0; ex = 0; er = 0; efn = '0;
        exp_q.push_back(pk(OP_BAR, 10'd24, 32'd7));
        for (int k = 0; k < 8; k++) exp_q.push_back(pk(OP_REG, 10'(1 + k), mid[32*k +: 32]));
        for (int k = 0; k < 3; k++) exp_q.push_back(pk(OP_REG, 10'(9 + k), wk[32*k +: 32]));
        exp_q.push_back(pk(OP_REG, 10'd20, 32'd1));
        exp_q.push_back(pk(OP_PC, 10'd0, 32'd2));
        exp_q.push_back(NULLP);
        n = ns;
        for (int it = 0; it < 64; it++) begin
            exp_q.push_back(pk(OP_REG, 10'd1, n));
            exp_q.push_back(pk(OP_REG, 10'd20, 32'd2));
            exp_q.push_back(pk(OP_PC, 10'd0, 32'd2));
            exp_q.push_back(NULLP);
            if (err_mode) begin er = 1; break; end
            if (hit_en && n == hit_n) begin ef = 1; efn = n; break; end
            if (n == nl) begin ex = 1; break; end
            n = n + 32'd1;
        end
        if (!er) begin
            exp_q.push_back(pk(OP_REG, 10'd20, 32'd3));
            exp_q.push_back(pk(OP_PC, 10'd0, 32'd2));
            exp_q.push_back(NULLP);
            if (done_resp != 3'b000) er = 1;
        end
    endtask

    task automatic run_job(input string name, input logic [31:0] ns, input logic [31:0] nl);
        logic [255:0] mid;
        logic [95:0]  wk;
        net_packet_s  p;
        int           cyc, last_pkt_cyc, n;
        for (int k = 0; k < 8; k++) mid[32*k +: 32] = $urandom();
        for (int k = 0; k < 3; k++) wk[32*k +: 32] = $urandom();
        build_expect(mid, wk, ns, nl);
        got_q.delete();
        @(negedge clk);
        midstate_i = mid; work_i = wk; nonce_start_i = ns; nonce_last_i = nl; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check($sformatf("%s/busy_rise", name), busy_o, 1);
        check($sformatf("%s/flags_clr", name), {found_o, exhausted_o, error_o}, 0);
        // Scramble inputs and pulse start mid-job: both must be ignored.
        midstate_i = ~mid; work_i = ~wk; nonce_start_i = ns + 32'd5; nonce_last_i = ~nl;
        cyc = 0;
        last_pkt_cyc = 0;
        while (busy_o && cyc < 4000) begin
            p = net_packet_o;
            if (p != NULLP) last_pkt_cyc = cyc;
            if (!(p == NULLP && (got_q.size() == 0 || got_q[$] == NULLP))) got_q.push_back(p);
            start_i = (cyc == 6);
            @(negedge clk);
            cyc++;
        end
        start_i = 1'b0;
        check($sformatf("%s/finished", name), busy_o, 0);
        check($sformatf("%s/len", name), got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s/pkt%0d", name, i), got_q[i], exp_q[i]);
        if (done_resp == 3'b001 && !er)
            check($sformatf("%s/never", name), 0, 1);
        if (done_resp == 3'b001 && !err_mode)
            check($sformatf("%s/tmo_len", name),
                  (cyc - last_pkt_cyc >= int'(TMO)) && (cyc - last_pkt_cyc <= int'(TMO) + 3), 1);
        else
            check($sformatf("%s/tail_len", name), cyc - last_pkt_cyc, SETTLE + 2);
        repeat (2) @(negedge clk);
        check($sformatf("%s/found", name), found_o, ef);
        check($sformatf("%s/exhausted", name), exhausted_o, ex);
        check($sformatf("%s/error", name), error_o, er);
        check($sformatf("%s/busy_idle", name), busy_o, 0);
        check($sformatf("%s/null_idle", name), net_packet_o, NULLP);
        if (ef) check($sformatf("%s/found_nonce", name), found_nonce_o, efn);
    endtask

    task automatic set_model(input logic [2:0] stale, input logic [2:0] dresp,
                             input bit em, input bit he, input logic [31:0] hn);
        stale_val = stale; done_resp = dresp; err_mode = em; hit_en = he; hit_n = hn;
    endtask

    initial begin
        logic [31:0] ns;
        for (int i = 0; i < 32; i++) cregs[i] = '0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst%0d/pkt", i), net_packet_o, NULLP);
            check($sformatf("rst%0d/flags", i), {busy_o, found_o, exhausted_o, error_o}, 0);
        end
        reset = 1'b0;

        set_model(3'b000, 3'b000, 0, 0, '0);
        run_job("exhaust_5_7", 32'd5, 32'd7);
        set_model(3'b011, 3'b000, 0, 1, 32'd6);
        run_job("hit_6", 32'd4, 32'd9);
        set_model(3'b001, 3'b000, 0, 0, '0);
        run_job("single_ffff", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        set_model(3'b001, 3'b000, 0, 1, 32'h2);
        run_job("wrap", 32'hFFFF_FFFE, 32'h1);
        set_model(3'b000, 3'b000, 1, 0, '0);
        run_job("bad_barrier", 32'd100, 32'd103);
        set_model(3'b000, 3'b001, 0, 1, 32'd21);
        run_job("never_clears", 32'd20, 32'd22);

        // Reset from DONE with sticky flags, then reset mid-MID
        reset = 1'b1;
        @(negedge clk);
        check("rst_done/flags", {busy_o, found_o, exhausted_o, error_o}, 0);
        reset = 1'b0;
        midstate_i = {8{32'hA5A5_0001}}; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid/in_mid", net_packet_o.op, OP_REG);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid/pkt", net_packet_o, NULLP);
        check("rst_mid/busy", busy_o, 0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid/idle_pkt", net_packet_o, NULLP);

        for (int j = 0; j < 8; j++) begin
            ns = $urandom();
            set_model(3'($urandom_range(0, 7)), 3'b000, 0, ($urandom_range(0, 1) == 1),
                      ns + 32'($urandom_range(0, 4)));
            run_job($sformatf("rand%0d", j), ns, ns + 32'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad + 1);
        $fatal(1, "global timeout");
    end

endmodule
